aes_job_scheduler: RTL

- Sequences and shares one AES encrypt core and one AES decrypt core (fixed-latency, free-running on `clk`/`rst`) between two requesters.
- Accepts jobs (mode, key, data) on two valid/ready channels and arbitrates round-robin.
- Holds the granted job's operands stable on the core inputs for the core latency, then captures the selected core output.
- Returns the result, tagged with requester id and mode, on a valid/ready result channel. Sits between system bus logic and the AES datapath.

---
 rtl/aes_job_scheduler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: shares one fixed-latency AES encrypt core and one AES
// decrypt core between two requesters. Jobs are granted round-robin, their
// operands are held on the core inputs for LAT cycles, and the selected core
// output is returned on a valid/ready result channel tagged with id and mode.
module aes_job_scheduler #(
    parameter int unsigned LEN = 128,
    parameter int unsigned LAT = 11,
    parameter int unsigned CW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic           req0_mode,
    input  logic [LEN-1:0] req0_key,
    input  logic [LEN-1:0] req0_data,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic           req1_mode,
    input  logic [LEN-1:0] req1_key,
    input  logic [LEN-1:0] req1_data,
    output logic [LEN-1:0] core_key,
    output logic [LEN-1:0] core_enc_in,
    output logic [LEN-1:0] core_dec_in,
    input  logic [LEN-1:0] core_enc_out,
    input  logic [LEN-1:0] core_dec_out,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [LEN-1:0] res_data,
    output logic           res_id,
    output logic           res_mode,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           rr_ptr;     // requester favoured when both are valid
    logic           job_mode;
    logic           job_id;
    logic [CW-1:0]  cnt;
    logic           grant_id;
    logic           accept;
    logic           sel_mode;
    logic [LEN-1:0] sel_key;
    logic [LEN-1:0] sel_data;

    // Round-robin grant and the operands of the granted requester
    always_comb begin
        grant_id = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        sel_mode = grant_id ? req1_mode : req0_mode;
        sel_key  = grant_id ? req1_key  : req0_key;
        sel_data = grant_id ? req1_data : req0_data;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    // Job sequencing: accept, hold operands on the cores for LAT cycles,
    // capture the selected core output, then wait for the consumer.
    // The core input registers double as the job operand storage, so they
    // are loaded on accept and cleared when the result is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            job_mode    <= 1'b0;
            job_id      <= 1'b0;
            cnt         <= '0;
            core_key    <= '0;
            core_enc_in <= '0;
            core_dec_in <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_id      <= 1'b0;
            res_mode    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        job_mode    <= sel_mode;
                        job_id      <= grant_id;
                        rr_ptr      <= ~grant_id;
                        cnt         <= CW'(LAT - 1);
                        core_key    <= sel_key;
                        core_enc_in <= sel_mode ? '0 : sel_data;
                        core_dec_in <= sel_mode ? sel_data : '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        res_data    <= job_mode ? core_dec_out : core_enc_out;
                        res_id      <= job_id;
                        res_mode    <= job_mode;
                        res_valid   <= 1'b1;
                        core_key    <= '0;
                        core_enc_in <= '0;
                        core_dec_in <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
